// File: rtl/net_packet_arbiter_pkg.sv
// Shared types for the network packet arbiter: packet format,
// network opcodes and arbiter FSM states.
package net_packet_arbiter_pkg;

   typedef enum logic [2:0] {
      NULL  = 3'd0,
      INSTR = 3'd1,
      REG   = 3'd2,
      PC    = 3'd3,
      BAR   = 3'd4
   } net_op_e;

   typedef struct packed {
      net_op_e     net_op;
      logic [15:0] addr;
      logic [31:0] data;
   } net_packet_s;

   typedef enum logic {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } net_arb_state_e;

endpackage

// File: rtl/net_packet_arbiter_rr_pick.sv
// Round-robin priority pick: first valid requester at or after rr_ptr,
// wrapping at num_req_p.
module net_packet_arbiter_rr_pick #(
   parameter int num_req_p = 2
) (
   input  logic [num_req_p-1:0]         valid,
   input  logic [$clog2(num_req_p)-1:0] rr_ptr,
   output logic [num_req_p-1:0]         grant,
   output logic                         found
);

   localparam int iw = $clog2(num_req_p);

   int k;

   always_comb begin
      grant = '0;
      found = 1'b0;
      k     = 0;
      for (int i = 0; i < num_req_p; i++) begin
         k = int'(rr_ptr) + i;
         if (k >= num_req_p)
            k = k - num_req_p;
         if (!found && valid[k[iw-1:0]]) begin
            grant[k[iw-1:0]] = 1'b1;
            found            = 1'b1;
         end
      end
   end

endmodule

// File: rtl/net_packet_arbiter.sv
// Round-robin packet arbiter with burst locking and a registered output.
// NET_PACKET_ARBITER_STALL_COUNT_EN enables the output stall counter.
module net_packet_arbiter
   import net_packet_arbiter_pkg::*;
#(
   parameter int num_req_p   = 2,
   parameter int max_burst_p = 8
) (
   input  logic                            clk,
   input  logic                            n_reset,
   input  net_packet_s [num_req_p-1:0]     req_packet_i,
   input  logic [num_req_p-1:0]            req_lock_i,
   output logic [num_req_p-1:0]            req_ready_o,
   output net_packet_s                     net_packet_o,
   input  logic                            net_ready_i,
   output logic [$clog2(num_req_p)-1:0]    grant_id_o,
   output logic [31:0]                     stall_count_o
);

   localparam int iw = $clog2(num_req_p);
   localparam logic [iw-1:0] last_id = iw'(num_req_p - 1);
   localparam logic [7:0] burst_max = 8'(max_burst_p);

   net_arb_state_e state, state_next;
   logic [iw-1:0] rr_ptr, rr_next;
   logic [iw-1:0] lock_id, lock_id_next;
   logic [iw-1:0] grant_next, pick_id;
   logic [7:0] burst_cnt, burst_next;
   logic [num_req_p-1:0] eligible, pick;
   logic found, load, accept, out_valid;
   logic pick_lock, pick_pc, release_hold;
   net_packet_s pick_pkt;

   // While locked, only the lock owner may compete.
   always_comb begin
      eligible = '0;
      for (int i = 0; i < num_req_p; i++)
         eligible[i] = (req_packet_i[i].net_op != NULL) &&
                       (state == ARB || lock_id == iw'(i));
   end

   net_packet_arbiter_rr_pick #(
      .num_req_p(num_req_p)
   ) rr_pick (
      .valid  (eligible),
      .rr_ptr (rr_ptr),
      .grant  (pick),
      .found  (found)
   );

   always_comb begin
      pick_id  = '0;
      pick_pkt = '0;
      for (int i = 0; i < num_req_p; i++) begin
         if (pick[i]) begin
            pick_id  = iw'(i);
            pick_pkt = req_packet_i[i];
         end
      end
   end

   assign pick_lock   = req_lock_i[pick_id];
   assign pick_pc     = (pick_pkt.net_op == PC);
   assign out_valid   = (net_packet_o.net_op != NULL);
   assign load        = !out_valid || net_ready_i;
   // Grants stay off for one cycle after reset release.
   assign accept      = load && found && !n_reset && !release_hold;
   assign req_ready_o = accept ? pick : '0;

   always_comb begin
      state_next   = state;
      lock_id_next = lock_id;
      burst_next   = burst_cnt;
      rr_next      = rr_ptr;
      grant_next   = grant_id_o;
      if (accept) begin
         grant_next = pick_id;
         rr_next    = (pick_id == last_id) ? '0 : pick_id + iw'(1);
         unique case (state)
            ARB: begin
               if (pick_lock && !pick_pc && burst_max > 8'd1) begin
                  state_next   = LOCKED;
                  lock_id_next = pick_id;
                  burst_next   = 8'd1;
               end
            end
            LOCKED: begin
               if (!pick_lock || pick_pc ||
                   burst_cnt + 8'd1 >= burst_max) begin
                  state_next = ARB;
                  burst_next = 8'd0;
               end else begin
                  burst_next = burst_cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (n_reset) begin
         state        <= ARB;
         rr_ptr       <= '0;
         lock_id      <= '0;
         burst_cnt    <= '0;
         grant_id_o   <= '0;
         net_packet_o <= '0;
         release_hold <= 1'b1;
      end else begin
         state        <= state_next;
         rr_ptr       <= rr_next;
         lock_id      <= lock_id_next;
         burst_cnt    <= burst_next;
         grant_id_o   <= grant_next;
         release_hold <= 1'b0;
         if (load)
            net_packet_o <= accept ? pick_pkt : '0;
      end
   end

`ifdef NET_PACKET_ARBITER_STALL_COUNT_EN
   logic [31:0] stall_count;

   always_ff @(posedge clk) begin
      if (n_reset)
         stall_count <= '0;
      else if (out_valid && !net_ready_i && stall_count != 32'hFFFF_FFFF)
         stall_count <= stall_count + 32'd1;
   end

   assign stall_count_o = stall_count;
`else
   assign stall_count_o = '0;
`endif

endmodule

// File: tb/tb_net_packet_arbiter.sv
// Scoreboard bench for net_packet_arbiter: two requesters, burst limit 4.
module tb_net_packet_arbiter;
   import net_packet_arbiter_pkg::*;

`ifdef NET_PACKET_ARBITER_STALL_COUNT_EN
   localparam logic [31:0] exp_stall = 32'd5;
`else
   localparam logic [31:0] exp_stall = 32'd0;
`endif

   logic clk = 1'b0;
   logic n_reset;
   net_packet_s [1:0] req_packet;
   logic [1:0] req_lock;
   logic [1:0] req_ready;
   net_packet_s net_packet;
   logic net_ready;
   logic [0:0] grant_id;
   logic [31:0] stall_count;

   typedef struct {
      net_packet_s pkt;
      logic        lock;
   } src_t;

   typedef struct {
      net_packet_s pkt;
      int          id;
   } exp_t;

   src_t src0[$];
   src_t src1[$];
   exp_t exp_q[$];
   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   net_packet_arbiter #(
      .num_req_p   (2),
      .max_burst_p (4)
   ) dut (
      .clk           (clk),
      .n_reset       (n_reset),
      .req_packet_i  (req_packet),
      .req_lock_i    (req_lock),
      .req_ready_o   (req_ready),
      .net_packet_o  (net_packet),
      .net_ready_i   (net_ready),
      .grant_id_o    (grant_id),
      .stall_count_o (stall_count)
   );

   function automatic net_packet_s mk(net_op_e op, int id, int seq);
      net_packet_s p;
      p.net_op = op;
      p.addr   = 16'((id << 8) | seq);
      p.data   = 32'hC0DE_0000 ^ 32'((id << 12) + seq * 3 + 1);
      return p;
   endfunction

   task automatic send(int id, net_op_e op, int seq, logic lock);
      src_t s;
      s.pkt  = mk(op, id, seq);
      s.lock = lock;
      if (id == 0) src0.push_back(s);
      else src1.push_back(s);
   endtask

   task automatic expect_pkt(int id, net_op_e op, int seq);
      exp_t e;
      e.pkt = mk(op, id, seq);
      e.id  = id;
      exp_q.push_back(e);
   endtask

   // One clock: drive heads of the source queues, score any output
   // transfer, retire consumed packets, return on the next negedge.
   task automatic step();
      exp_t e;
      req_packet[0] = (src0.size() > 0) ? src0[0].pkt : '0;
      req_lock[0]   = (src0.size() > 0) ? src0[0].lock : 1'b0;
      req_packet[1] = (src1.size() > 0) ? src1[0].pkt : '0;
      req_lock[1]   = (src1.size() > 0) ? src1[0].lock : 1'b0;
      #1;
      if (net_packet.net_op != NULL && net_ready) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_pkt got=%h want=none", net_packet);
         end else begin
            e = exp_q.pop_front();
            if (net_packet !== e.pkt || grant_id !== 1'(e.id)) begin
               n_err++;
               $display("FAIL pkt_out got=%h/id%0d want=%h/id%0d",
                        net_packet, grant_id, e.pkt, e.id);
            end
         end
      end
      if (req_ready != 2'b00) begin
         n_cmp++;
         if ($countones(req_ready) != 1 ||
             (req_ready[0] && src0.size() == 0) ||
             (req_ready[1] && src1.size() == 0)) begin
            n_err++;
            $display("FAIL ready_onehot got=%b want=onehot_valid", req_ready);
         end
      end
      if (req_ready[0] && src0.size() > 0) void'(src0.pop_front());
      if (req_ready[1] && src1.size() > 0) void'(src1.pop_front());
      @(negedge clk);
   endtask

   task automatic drain(output int steps);
      steps = 0;
      while ((exp_q.size() > 0 || src0.size() > 0 || src1.size() > 0) &&
             steps < 200) begin
         step();
         steps++;
      end
      n_cmp++;
      if (exp_q.size() != 0 || src0.size() != 0 || src1.size() != 0) begin
         n_err++;
         $display("FAIL drain_timeout got=%0d_left want=0", exp_q.size());
      end
   endtask

   task automatic apply_reset();
      n_reset = 1'b1;
      net_ready = 1'b1;
      src0.delete();
      src1.delete();
      exp_q.delete();
      step();
      step();
      n_reset = 1'b0;
      step();
      step();
   endtask

   task automatic test_reset();
      int steps;
      send(0, INSTR, 0, 1'b0);
      send(1, INSTR, 0, 1'b0);
      expect_pkt(0, INSTR, 0);
      expect_pkt(1, INSTR, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++;
         if (net_packet !== '0 || req_ready !== 2'b00) begin
            n_err++;
            $display("FAIL reset_state got=%h/%b want=0/00", net_packet, req_ready);
         end
         n_cmp++;
         if (grant_id !== 1'b0 || stall_count !== 32'd0) begin
            n_err++;
            $display("FAIL reset_regs got=%0d/%0d want=0/0", grant_id, stall_count);
         end
      end
      n_reset = 1'b0;
      #1;
      n_cmp++;
      if (req_ready !== 2'b00) begin
         n_err++;
         $display("FAIL release_ready got=%b want=00", req_ready);
      end
      step();
      n_cmp++;
      if (net_packet.net_op !== NULL) begin
         n_err++;
         $display("FAIL release_idle got=%h want=NULL", net_packet);
      end
      step();
      n_cmp++;
      if (net_packet !== mk(INSTR, 0, 0)) begin
         n_err++;
         $display("FAIL first_pkt got=%h want=%h", net_packet, mk(INSTR, 0, 0));
      end
      drain(steps);
   endtask

   task automatic test_round_robin();
      int steps;
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         send(0, INSTR, i, 1'b0);
         send(1, INSTR, i, 1'b0);
         expect_pkt(0, INSTR, i);
         expect_pkt(1, INSTR, i);
      end
      drain(steps);
      n_cmp++;
      if (steps != 9) begin
         n_err++;
         $display("FAIL rr_throughput got=%0d want=9", steps);
      end
   endtask

   task automatic test_lock();
      int steps;
      apply_reset();
      send(0, REG, 0, 1'b1);
      send(0, REG, 1, 1'b1);
      send(0, REG, 2, 1'b0);
      send(1, INSTR, 0, 1'b0);
      send(1, INSTR, 1, 1'b0);
      expect_pkt(0, REG, 0);
      expect_pkt(0, REG, 1);
      expect_pkt(0, REG, 2);
      expect_pkt(1, INSTR, 0);
      expect_pkt(1, INSTR, 1);
      drain(steps);
   endtask

   task automatic test_lock_idle();
      int steps;
      apply_reset();
      send(0, REG, 0, 1'b1);
      send(1, INSTR, 0, 1'b0);
      expect_pkt(0, REG, 0);
      for (int i = 0; i < 4; i++) step();
      n_cmp++;
      if (src1.size() != 1) begin
         n_err++;
         $display("FAIL lock_idle_wait got=%0d want=1", src1.size());
      end
      for (int i = 1; i <= 4; i++) send(0, REG, i, 1'b1);
      expect_pkt(0, REG, 1);
      expect_pkt(0, REG, 2);
      expect_pkt(0, REG, 3);
      expect_pkt(1, INSTR, 0);
      expect_pkt(0, REG, 4);
      drain(steps);
   endtask

   task automatic test_forced_release();
      int steps;
      apply_reset();
      for (int i = 0; i < 5; i++) send(0, INSTR, i, 1'b1);
      send(1, INSTR, 0, 1'b0);
      for (int i = 0; i < 4; i++) expect_pkt(0, INSTR, i);
      expect_pkt(1, INSTR, 0);
      expect_pkt(0, INSTR, 4);
      drain(steps);
   endtask

   task automatic test_backpressure();
      int steps;
      apply_reset();
      send(0, REG, 0, 1'b0);
      send(0, REG, 1, 1'b0);
      expect_pkt(0, REG, 0);
      expect_pkt(0, REG, 1);
      step();
      net_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         n_cmp++;
         if (net_packet !== mk(REG, 0, 0) || req_ready !== 2'b00) begin
            n_err++;
            $display("FAIL stall_hold got=%h/%b want=%h/00",
                     net_packet, req_ready, mk(REG, 0, 0));
         end
      end
      n_cmp++;
      if (stall_count !== exp_stall) begin
         n_err++;
         $display("FAIL stall_count got=%0d want=%0d", stall_count, exp_stall);
      end
      net_ready = 1'b1;
      drain(steps);
      n_cmp++;
      if (stall_count !== exp_stall) begin
         n_err++;
         $display("FAIL stall_after got=%0d want=%0d", stall_count, exp_stall);
      end
   endtask

   task automatic test_reset_mid_stall();
      int steps;
      apply_reset();
      net_ready = 1'b0;
      send(0, REG, 0, 1'b1);
      send(0, REG, 1, 1'b1);
      step();
      step();
      step();
      n_reset = 1'b1;
      src0.delete();
      src1.delete();
      exp_q.delete();
      step();
      n_cmp++;
      if (net_packet !== '0 || req_ready !== 2'b00 || stall_count !== 32'd0) begin
         n_err++;
         $display("FAIL mid_reset got=%h/%b/%0d want=0/00/0",
                  net_packet, req_ready, stall_count);
      end
      n_reset = 1'b0;
      net_ready = 1'b1;
      send(1, INSTR, 7, 1'b0);
      expect_pkt(1, INSTR, 7);
      #1;
      n_cmp++;
      if (req_ready !== 2'b00) begin
         n_err++;
         $display("FAIL mid_release_ready got=%b want=00", req_ready);
      end
      step();
      n_cmp++;
      if (net_packet.net_op !== NULL) begin
         n_err++;
         $display("FAIL mid_release_idle got=%h want=NULL", net_packet);
      end
      drain(steps);
   endtask

   task automatic test_pc_release();
      int steps;
      apply_reset();
      send(1, INSTR, 0, 1'b1);
      send(1, PC, 1, 1'b1);
      send(1, INSTR, 2, 1'b0);
      expect_pkt(1, INSTR, 0);
      expect_pkt(1, PC, 1);
      expect_pkt(0, REG, 0);
      expect_pkt(1, INSTR, 2);
      step();
      send(0, REG, 0, 1'b0);
      drain(steps);
   endtask

   initial begin
      n_reset    = 1'b1;
      net_ready  = 1'b1;
      req_packet = '0;
      req_lock   = '0;
      test_reset();
      test_round_robin();
      test_lock();
      test_lock_idle();
      test_forced_release();
      test_backpressure();
      test_reset_mid_stall();
      test_pc_release();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

endmodule
